// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-stream requester and uart_tx handshake bundle
//
// Groups the requester-side streams and the uart_tx-side stream of the arbiter.
//   req_data  : requester i data in slice [i*DataWidth +: DataWidth]
//   req_valid : requester i has a byte
//   req_last  : byte is the final byte of requester i's packet
//   req_ready : byte of requester i accepted this cycle
//   tx_data   : to uart_tx data_in
//   tx_valid  : to uart_tx data_in_valid
//   tx_ready  : from uart_tx ready
// Modports: master = requesters plus uart_tx (environment), slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_last;
  logic [NumReq-1:0]           req_ready;
  logic [DataWidth-1:0]        tx_data;
  logic                        tx_valid;
  logic                        tx_ready;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of uart_tx
//
// Shares one uart_tx between NumReq byte-stream requesters. A grantee keeps the
// transmitter until its last byte (or MaxBeats beats) is accepted, so packets
// never interleave on the serial line. No buffering: the uart side sees the
// grantee's data/valid directly and the grantee sees tx_ready directly.
// Ports:
//   clk      : system clock
//   rst_n    : synchronous reset, active low
//   bus      : uart_tx_arbiter_if.slave (requester streams and uart_tx stream)
//   busy     : a grant is held
//   grant_id : index of the current grantee, 0 when idle
// Optional feature macro: UART_TX_ARBITER_SRC_TAG_EN - each packet is preceded
// by a tag byte {TagPrefix, grant_id}.
module uart_tx_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxBeats  = 0,
`ifdef UART_TX_ARBITER_SRC_TAG_EN
  parameter logic [3:0] TagPrefix = 4'hA,
`endif
  localparam int GW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CW = (MaxBeats > 0) ? $clog2(MaxBeats + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_arbiter_if.slave       bus,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);

`ifdef UART_TX_ARBITER_SRC_TAG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TAG} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY} state_t;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            hi_found, lo_found, any_valid;
  logic [GW-1:0]   pick_hi, pick_lo, pick;
  logic [DataWidth-1:0] sel_data;
  logic            sel_valid, sel_last;
  logic            release_grant;

  // Round-robin pick: lowest valid index at or above the pointer, else the
  // lowest valid index below it (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          pick_hi  = GW'(i);
        end else begin
          lo_found = 1'b1;
          pick_lo  = GW'(i);
        end
      end
    end
    any_valid = hi_found | lo_found;
    pick      = hi_found ? pick_hi : pick_lo;
  end

  // Grantee's stream.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (gid_q == GW'(i)) begin
        sel_data  = bus.req_data[i*DataWidth +: DataWidth];
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    cnt_d         = cnt_q;
    busy          = 1'b0;
    bus.tx_data   = '0;
    bus.tx_valid  = 1'b0;
    bus.req_ready = '0;
    release_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          gid_d = pick;
`ifdef UART_TX_ARBITER_SRC_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_BUSY;
`endif
        end
      end
`ifdef UART_TX_ARBITER_SRC_TAG_EN
      ST_TAG: begin
        busy         = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = DataWidth'({TagPrefix, 4'(gid_q)});
        if (bus.tx_ready) begin
          state_d = ST_BUSY;
        end
      end
`endif
      ST_BUSY: begin
        busy         = 1'b1;
        bus.tx_data  = sel_data;
        bus.tx_valid = sel_valid;
        for (int i = 0; i < NumReq; i++) begin
          bus.req_ready[i] = (gid_q == GW'(i)) & bus.tx_ready;
        end
        if (sel_valid && bus.tx_ready) begin
          cnt_d         = cnt_q + 1'b1;
          release_grant = sel_last;
          if (MaxBeats > 0) begin
            if (cnt_q == CW'(MaxBeats - 1)) begin
              release_grant = 1'b1;
            end
          end
          if (release_grant) begin
            state_d = ST_IDLE;
            ptr_d   = (gid_q == GW'(NumReq - 1)) ? '0 : gid_q + 1'b1;
            gid_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gid_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NumReq byte-stream requesters (pattern streamer, rx echo, debug/status sources) with packet-granular round-robin arbitration. A granted requester keeps the transmitter until its last byte is accepted, so packets never interleave on the serial line. The block sits between the requesters and uart_tx, whose handshake is data_in/data_in_valid/ready.

Parameters:
NumReq, 4, number of requesters (1..16)
DataWidth, 8, byte width (must be 8 when the tag feature is enabled)
MaxBeats, 0, forced release after this many accepted beats in one grant; 0 = unlimited
TagPrefix, 4'hA, upper nibble of the source tag byte (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
req_data  in  NumReq*DataWidth  requester i data in slice [i*DataWidth +: DataWidth]
req_valid  in  NumReq  requester i has a byte
req_last  in  NumReq  byte is the final byte of requester i's packet
req_ready  out  NumReq  byte of requester i accepted this cycle
tx_data  out  DataWidth  to uart_tx data_in
tx_valid  out  1  to uart_tx data_in_valid
tx_ready  in  1  from uart_tx ready
busy  out  1  a grant is held
grant_id  out  GW = max(1, clog2(NumReq))  index of the current grantee (0 when idle)

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active low, sampled on the rising clk edge.
- Beat: a transfer occurs on a cycle with tx_valid && tx_ready.
- States: IDLE and BUSY, plus TAG when the optional feature is compiled in.
- Reset (rst_n = 0 at an edge):
  - state = IDLE, priority pointer = 0, beat counter = 0
  - busy = 0, grant_id = 0, tx_valid = 0, req_ready = all 0, tx_data = 0
  - Applies mid-packet too: the partial packet is abandoned and nothing is replayed.
- IDLE:
  - tx_valid = 0, req_ready = 0.
  - If any req_valid is set, pick the first set bit scanning from the pointer upward with wrap.
  - Register that index into grant_id and go to BUSY; busy = 1 from the next cycle.
  - Latency: valid in cycle t gives tx_valid at t+1 at the earliest.
- BUSY:
  - tx_data = req_data[grant_id]; tx_valid = req_valid[grant_id].
  - req_ready[grant_id] = tx_ready; all other req_ready bits = 0. This path is combinational.
  - If the grantee drops valid mid-packet, the grant is held with tx_valid = 0 (no timeout unless MaxBeats > 0).
  - Release condition: a beat with req_last[grant_id] = 1, or a beat that makes the beat count reach MaxBeats (MaxBeats > 0).
  - On release: next state IDLE; pointer = (grant_id + 1) mod NumReq; beat counter cleared; busy = 0 next cycle.
  - One IDLE cycle always separates consecutive grants.
- Beat counter: width clog2(MaxBeats + 1); counts beats within one grant and is never compared when MaxBeats = 0.
- Backpressure: tx_data/tx_valid follow the grantee and must stay stable while tx_ready = 0. The block adds no buffering, so no byte is lost or duplicated.
- Late requests: new requests arriving during BUSY are ignored until IDLE.
- Single requester: with NumReq = 1, grant_id is always 0 and the pointer stays 0.

Optional Feature:
Macro UART_TX_ARBITER_SRC_TAG_EN.
- Defined:
  - IDLE goes to TAG instead of BUSY.
  - TAG drives tx_valid = 1 and tx_data = {TagPrefix, grant_id zero-extended to 4 bits}, with req_ready = 0.
  - On tx_ready, go to BUSY.
  - The tag beat does not count toward MaxBeats.
  - Reset during TAG goes to IDLE.
- Undefined: no TAG state and no tag logic; packets go out untagged.

Test Plan:
- Requester 1 alone sends 0x41, 0x42, 0x43 (last on 0x43), tx_ready held 1 -> grant_id = 1 and busy = 1 one cycle after valid; tx_data 0x41, 0x42, 0x43 on 3 consecutive cycles; req_ready[1] high those 3 cycles; busy = 0 the cycle after.
- All 4 requesters valid together right after reset, each sending a 2-byte packet -> grants in order 0, 1, 2, 3; each packet contiguous; one idle cycle between packets; pointer back to 0.
- Requester 2 packet 0x10..0x14 with tx_ready pattern 1, 0, 0, 1, 0, 1, 1, 1 -> tx_data stable while ready is low; uart sees exactly 0x10..0x14 once each.
- MaxBeats = 4; requester 0 streams 10 bytes with no last while requester 3 is valid -> release after 4 beats, grant_id = 3 next, then back to 0 for the remaining bytes.
- rst_n = 0 for one cycle after the 2nd byte of a 5-byte packet -> next cycle busy = 0, tx_valid = 0, req_ready = 0, grant_id = 0; a fresh arbitration starts from requester 0.
- With UART_TX_ARBITER_SRC_TAG_EN, requester 2 sends 0x55 (last) -> uart sees 0xA2 then 0x55; req_ready[2] stays low during the tag beat.
